tst_activity_monitor: RTL and testbench
=======================================

Name: tst_activity_monitor

Overview:
- Downstream consumer of the four free-running test-probe lines (tst1..tst4) driven by the board test-pattern generator.
- Synchronises each line and counts its rising edges over a fixed measurement window.
- Latches per-channel counts at each window close and raises sticky "stuck" alarms for lines that stop toggling.
- Results are read back through a simple mux port for the control/debug interface.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchroniser stages per input line (legal range 2..4).
- WIN_LEN, 4194304, measurement window length in clk cycles (legal range 4..2^24).
- CNT_W, 16, width of each per-channel edge counter and of each latched result.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  measurement enable.
- clr  in  1  synchronous clear of the sticky stuck flags.
- tst_in  in  4  probe lines; bit0=tst1 ... bit3=tst4. Asynchronous to clk.
- rd_sel  in  2  selects which channel's latched result drives rd_data.
- rd_data  out  CNT_W  latched edge count of the selected channel.
- done  out  1  one-cycle pulse when new results are latched.
- act  out  4  per channel: 1 if the last completed window counted at least one edge.
- stuck  out  4  sticky per channel: set when any completed window counted zero edges.
- win_num  out  8  number of completed windows, wraps 255 -> 0.

Behaviour:
- Reset: clk is the only clock and rst_n is an asynchronous, active-low reset. While rst_n = 0, every register is cleared:
  - synchroniser chains, edge counters, window counter and result registers = 0;
  - done = 0, act = 0, stuck = 0, win_num = 0, rd_data = 0.
- Reset mid-window: the partial window is discarded.
- Synchroniser: each tst_in bit passes through SYNC_STAGES flip-flops. The synchronised value s[i] feeds a previous-value register p[i].
- Edge detect:
  - rise[i] = s[i] & ~p[i] & primed.
  - primed is cleared by reset and set on the first clk edge with en = 1.
  - A line that is already high out of reset is therefore not counted.
  - Input-to-count latency is SYNC_STAGES+1 cycles.
- Window counter wc:
  - When en = 1, wc counts 0..WIN_LEN-1.
  - When en = 0, wc and all edge counters are held at 0, primed is cleared, and result registers are retained.
- Edge counters:
  - ec[i] increments on rise[i].
  - ec[i] saturates at 2^CNT_W-1 and never wraps.
- Window close (en = 1 and wc = WIN_LEN-1), at the next clk edge:
  - res[i] <= sat(ec[i] + rise[i]); a rise in the closing cycle belongs to the closing window;
  - ec[i] <= 0 and wc <= 0;
  - act[i] <= (result != 0);
  - stuck[i] <= stuck[i] | (result == 0);
  - win_num <= win_num + 1;
  - done = 1 for exactly that one following cycle.
- Simultaneous clr and window close: the set takes priority, so stuck[i] reflects the new result.
- clr with no close: stuck <= 0.
- rd_data:
  - Registered: rd_data <= res[rd_sel] on every clk edge, giving 1-cycle read latency.
  - In the done cycle, rd_data still shows the previous window; the new value appears one cycle later.
- en dropped mid-window: the partial window is discarded with no close event, and done is not asserted.
- State: IDLE (en = 0) -> MEASURE (en = 1). MEASURE -> MEASURE at each window close. Any state -> IDLE on en = 0.

Test Plan:
- Reset with tst_in = 4'hF, release, en = 1, WIN_LEN = 16, inputs static → no edges counted; after the first close act = 0, stuck = 4'hF, rd_data = 0, win_num = 1.
- WIN_LEN = 16, tst_in[0] toggling with period 4 (high 2 / low 2), other channels low → each window res0 = 4, act = 4'b0001, stuck = 4'b1110, done high exactly 1 cycle per 16.
- Rising edge timed so the synchronised rise lands in the cycle wc = 15 → the edge is counted in the closing window (count 1), and the next window starts at 0.
- CNT_W = 4, WIN_LEN = 64, tst_in[1] toggling every cycle → res1 saturates at 15, not 0.
- clr asserted in the same cycle as a zero-edge close on ch2 → stuck[2] = 1. clr asserted one cycle later → stuck[2] = 0.
- en deasserted at wc = 10, then reasserted → no done pulse, res unchanged, and the next close occurs 16 cycles after reassertion. Repeat with rst_n pulsed low at wc = 10: all outputs return to 0 immediately.

Source files
------------

// File: rtl/tst_activity_monitor.sv
// Per-channel rising-edge activity monitor for the four board test-probe lines.
// Counts synchronised edges over a fixed window, latches results and flags stuck lines.
module tst_activity_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WIN_LEN     = 4194304,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [3:0]       tst_in,
    input  logic [1:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             done,
    output logic [3:0]       act,
    output logic [3:0]       stuck,
    output logic [7:0]       win_num
);

    localparam int unsigned NCH  = 4;
    localparam int unsigned WC_W = $clog2(WIN_LEN);
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [NCH-1:0]   sync_q [SYNC_STAGES];
    logic [NCH-1:0]   prev_q;
    logic [NCH-1:0]   rise_c;
    logic [NCH-1:0]   zero_c;
    logic [WC_W-1:0]  wc_q;
    logic [CNT_W-1:0] ec_q      [NCH];
    logic [CNT_W-1:0] res_q     [NCH];
    logic [CNT_W-1:0] win_res_c [NCH];
    logic             primed_c;
    logic             close_c;

    // Input synchronisers plus previous-value register for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= tst_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Being in MEASURE means at least one edge has seen en = 1, i.e. primed
    always_comb begin
        state_d  = state_q;
        primed_c = 1'b0;
        close_c  = 1'b0;
        case (state_q)
            IDLE:    if (en)  state_d = MEASURE;
            MEASURE: begin
                primed_c = 1'b1;
                if (!en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        close_c = en && (wc_q == WC_LAST);
    end

    assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q & {NCH{primed_c}};

    // Saturating count including any rise in the current cycle
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            win_res_c[i] = (ec_q[i] == CNT_MAX) ? CNT_MAX : ec_q[i] + CNT_W'(rise_c[i]);
            zero_c[i]    = (win_res_c[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc_q <= '0;
            for (int i = 0; i < NCH; i++) ec_q[i] <= '0;
        end else if (!en || close_c) begin
            wc_q <= '0;
            for (int i = 0; i < NCH; i++) ec_q[i] <= '0;
        end else begin
            wc_q <= wc_q + WC_W'(1);
            for (int i = 0; i < NCH; i++) ec_q[i] <= win_res_c[i];
        end
    end

    // Result latch, alarms and read port; a close sets stuck ahead of a same-cycle clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) res_q[i] <= '0;
            done    <= 1'b0;
            act     <= '0;
            stuck   <= '0;
            win_num <= '0;
            rd_data <= '0;
        end else begin
            done    <= close_c;
            rd_data <= res_q[rd_sel];
            if (close_c) begin
                for (int i = 0; i < NCH; i++) res_q[i] <= win_res_c[i];
                act     <= ~zero_c;
                stuck   <= (clr ? 4'b0000 : stuck) | zero_c;
                win_num <= win_num + 8'd1;
            end else if (clr) begin
                stuck <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tst_activity_monitor.sv
// Directed bench for tst_activity_monitor: main instance (WIN_LEN=16) plus a
// narrow-counter instance (CNT_W=4, WIN_LEN=64) for saturation.
module tb_tst_activity_monitor;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic [3:0]  tst_in;
    logic [1:0]  rd_sel;
    logic [15:0] rd_data;
    logic        done;
    logic [3:0]  act;
    logic [3:0]  stuck;
    logic [7:0]  win_num;

    logic        sat_en;
    logic        sat_clr;
    logic [3:0]  sat_tst;
    logic [1:0]  sat_sel;
    logic [3:0]  sat_rd;
    logic        sat_done;
    logic [3:0]  sat_act;
    logic [3:0]  sat_stuck;
    logic [7:0]  sat_win;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    tst_activity_monitor #(.SYNC_STAGES(2), .WIN_LEN(16), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .tst_in(tst_in),
        .rd_sel(rd_sel), .rd_data(rd_data), .done(done), .act(act),
        .stuck(stuck), .win_num(win_num)
    );

    tst_activity_monitor #(.SYNC_STAGES(2), .WIN_LEN(64), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(sat_en), .clr(sat_clr), .tst_in(sat_tst),
        .rd_sel(sat_sel), .rd_data(sat_rd), .done(sat_done), .act(sat_act),
        .stuck(sat_stuck), .win_num(sat_win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Advance the main instance to edge 'target', checking done every cycle
    task automatic run_to(input int target);
        while (cyc < target) begin
            tick();
            chk("done", 32'(done), 32'(cyc % 16 == 0));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        clr     = 1'b0;
        tst_in  = 4'hF;
        rd_sel  = 2'd0;
        sat_en  = 1'b0;
        sat_clr = 1'b0;
        sat_tst = 4'h0;
        sat_sel = 2'd1;
        repeat (3) tick();
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_act",     32'(act),     32'd0);
        chk("rst_stuck",   32'(stuck),   32'd0);
        chk("rst_win_num", 32'(win_num), 32'd0);

        // Lines high out of reset must not count as edges
        rst_n = 1'b1;
        repeat (4) tick();
        en  = 1'b1;
        cyc = 0;
        run_to(16);
        chk("w1_win_num", 32'(win_num), 32'd1);
        chk("w1_act",     32'(act),     32'h0);
        chk("w1_stuck",   32'(stuck),   32'hF);
        chk("w1_rd_done", 32'(rd_data), 32'd0);
        run_to(17);
        chk("w1_rd_data", 32'(rd_data), 32'd0);

        // clr without a close clears the alarms
        tst_in = 4'h0;
        clr    = 1'b1;
        run_to(18);
        clr = 1'b0;
        chk("clr_stuck", 32'(stuck), 32'h0);

        // ch0 toggling period 4: window 2 sees 3 edges, later windows 4
        for (int e = 18; e < 65; e++) begin
            tst_in[0] = ((e - 18) % 4 < 2);
            tick();
            chk("tog_done", 32'(done), 32'(cyc % 16 == 0));
            if (cyc == 32 || cyc == 48 || cyc == 64) begin
                chk("tog_act",     32'(act),     32'h1);
                chk("tog_stuck",   32'(stuck),   32'hE);
                chk("tog_win_num", 32'(win_num), 32'(cyc / 16));
            end
            if (cyc == 33) chk("tog_res_w2", 32'(rd_data), 32'd3);
            if (cyc == 49) chk("tog_res_w3", 32'(rd_data), 32'd4);
            if (cyc == 65) chk("tog_res_w4", 32'(rd_data), 32'd4);
        end
        tst_in = 4'h0;

        // Rise lands in the wc = 15 cycle of window 6
        run_to(93);
        tst_in[0] = 1'b1;
        run_to(96);
        chk("edge_close_act", 32'(act), 32'h1);
        run_to(97);
        chk("edge_close_res", 32'(rd_data), 32'd1);

        // clr together with an all-zero close, then clr alone
        run_to(111);
        clr = 1'b1;
        run_to(112);
        chk("clr_close_stuck", 32'(stuck), 32'hF);
        chk("clr_close_stk2",  32'(stuck[2]), 32'd1);
        run_to(113);
        chk("clr_after_stuck", 32'(stuck), 32'h0);
        chk("next_win_res",    32'(rd_data), 32'd0);
        clr    = 1'b0;
        en     = 1'b0;
        tst_in = 4'h0;

        // Saturation: 17 rises into a 4-bit counter
        sat_en = 1'b1;
        for (int m = 0; m < 64; m++) begin
            sat_tst[1] = (m < 34) && (m % 2 == 0);
            tick();
            chk("sat_done", 32'(sat_done), 32'(m == 63));
        end
        sat_tst = 4'h0;
        tick();
        chk("sat_res",   32'(sat_rd),    32'd15);
        chk("sat_act",   32'(sat_act),   32'h2);
        chk("sat_stuck", 32'(sat_stuck), 32'hD);
        sat_en = 1'b0;

        // en dropped at wc = 10 after a window with res0 = 2
        en  = 1'b1;
        cyc = 0;
        for (int g = 0; g < 37; g++) begin
            tst_in[0] = (g == 1 || g == 2 || g == 5 || g == 6 || g == 18 || g == 19);
            if (g == 26) en = 1'b0;
            tick();
            chk("drop_done", 32'(done), 32'(cyc == 16));
            if (cyc == 17) chk("drop_res_w", 32'(rd_data), 32'd2);
        end
        chk("drop_res_kept", 32'(rd_data), 32'd2);
        chk("drop_win_num",  32'(win_num), 32'd8);

        // Re-enable: close exactly 16 edges later, partial edge discarded
        en  = 1'b1;
        cyc = 0;
        tick();
        chk("re_done", 32'(done), 32'd0);
        tst_in[0] = 1'b1;
        run_to(17);
        chk("re_res",     32'(rd_data), 32'd1);
        chk("re_win_num", 32'(win_num), 32'd9);
        chk("re_stuck",   32'(stuck),   32'hE);

        // Reset pulse mid-window clears every output at once
        run_to(26);
        chk("pre_rst_act", 32'(act), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
        chk("mid_rst_act",     32'(act),     32'h0);
        chk("mid_rst_stuck",   32'(stuck),   32'h0);
        chk("mid_rst_win_num", 32'(win_num), 32'd0);
        chk("mid_rst_done",    32'(done),    32'd0);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
